// File: rtl/match_controller.sv
// match_controller
// ----------------
// Match sequencer for the puzzle-battle game. It runs a start countdown,
// handles pause/resume/abort, detects the end of a match (time up or KO
// target reached), and reports a ranked winner.
//
// Ports:
//   clk          system clock
//   rst          asynchronous, active-high reset
//   tick         one-cycle 1 Hz pulse from the timebase
//   start_multi  menu pulse: start a multiplayer match
//   start_solo   menu pulse: start a solo match (player 0 only)
//   pause_req    pulse: toggle pause
//   back         pulse: return to menu / abort
//   time_up      match timer expired (level or pulse)
//   ko_bus       per-player KO counts, player i at [i*KO_W +: KO_W]
//   lines_bus    per-player lines-sent counts, same packing
//   state        current state (READY=0 .. SOLO_OVER=5)
//   countdown    remaining countdown seconds
//   timer_run    enables the external match timer
//   timer_clear  one-cycle pulse that clears the match timer
//   game_over    high while in RESULT or SOLO_OVER
//   winner       winning player index, valid while game_over
module match_controller #(
  parameter int NUM_PLAYERS = 4,
  parameter int KO_W        = 3,
  parameter int LINE_W      = 6,
  parameter int KO_TARGET   = 5,
  parameter int COUNT_SECS  = 3,
  parameter int PID_W       = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tick,
  input  logic                          start_multi,
  input  logic                          start_solo,
  input  logic                          pause_req,
  input  logic                          back,
  input  logic                          time_up,
  input  logic [NUM_PLAYERS*KO_W-1:0]   ko_bus,
  input  logic [NUM_PLAYERS*LINE_W-1:0] lines_bus,
  output logic [2:0]                    state,
  output logic [3:0]                    countdown,
  output logic                          timer_run,
  output logic                          timer_clear,
  output logic                          game_over,
  output logic [PID_W-1:0]              winner
);

  typedef enum logic [2:0] {
    ST_READY     = 3'd0,
    ST_COUNTDOWN = 3'd1,
    ST_PLAYING   = 3'd2,
    ST_PAUSED    = 3'd3,
    ST_RESULT    = 3'd4,
    ST_SOLO_OVER = 3'd5
  } state_t;

  state_t             state_q;
  logic               solo_q;
  logic [3:0]         countdown_q;
  logic               timer_run_q;
  logic               timer_clear_q;
  logic               game_over_q;
  logic [PID_W-1:0]   winner_q;

  // Unpacked per-player views of the packed buses.
  logic [KO_W-1:0]    ko_a    [NUM_PLAYERS];
  logic [LINE_W-1:0]  lines_a [NUM_PLAYERS];

  for (genvar gi = 0; gi < NUM_PLAYERS; gi++) begin : g_unpack
    assign ko_a[gi]    = ko_bus[gi*KO_W +: KO_W];
    assign lines_a[gi] = lines_bus[gi*LINE_W +: LINE_W];
  end

  // Ranking: a challenger only displaces the current best on a strictly
  // better (KO, lines) pair, so full ties stay with the lowest index.
  logic [KO_W-1:0]    best_ko;
  logic [LINE_W-1:0]  best_lines;
  logic [PID_W-1:0]   best_idx_d;
  logic               ko_hit_d;

  always_comb begin
    best_ko    = ko_a[0];
    best_lines = lines_a[0];
    best_idx_d = '0;
    for (int i = 1; i < NUM_PLAYERS; i++) begin
      if ((ko_a[i] > best_ko) ||
          ((ko_a[i] == best_ko) && (lines_a[i] > best_lines))) begin
        best_ko    = ko_a[i];
        best_lines = lines_a[i];
        best_idx_d = PID_W'(i);
      end
    end
  end

  always_comb begin
    ko_hit_d = 1'b0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (32'(ko_a[i]) >= 32'(KO_TARGET)) ko_hit_d = 1'b1;
    end
  end

  // Solo matches ignore KO counts entirely; only the timer ends them.
  logic end_cond_d;
  assign end_cond_d = solo_q ? time_up : (time_up | ko_hit_d);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_READY;
      solo_q        <= 1'b0;
      countdown_q   <= 4'd0;
      timer_run_q   <= 1'b0;
      timer_clear_q <= 1'b0;
      game_over_q   <= 1'b0;
      winner_q      <= '0;
    end else begin
      timer_clear_q <= 1'b0;
      case (state_q)
        ST_READY: begin
          if (start_multi || start_solo) begin
            solo_q        <= ~start_multi;  // multi wins a simultaneous start
            countdown_q   <= 4'(COUNT_SECS);
            timer_clear_q <= 1'b1;
            state_q       <= ST_COUNTDOWN;
          end
        end
        ST_COUNTDOWN: begin
          if (back) begin
            countdown_q <= 4'd0;
            state_q     <= ST_READY;
          end else if (tick) begin
            if (countdown_q <= 4'd1) begin
              countdown_q <= 4'd0;
              timer_run_q <= 1'b1;
              state_q     <= ST_PLAYING;
            end else begin
              countdown_q <= countdown_q - 4'd1;
            end
          end
        end
        ST_PLAYING: begin
          if (end_cond_d) begin
            timer_run_q <= 1'b0;
            game_over_q <= 1'b1;
            winner_q    <= solo_q ? '0 : best_idx_d;
            state_q     <= solo_q ? ST_SOLO_OVER : ST_RESULT;
          end else if (back) begin
            timer_run_q <= 1'b0;
            state_q     <= ST_READY;
          end else if (pause_req) begin
            timer_run_q <= 1'b0;
            state_q     <= ST_PAUSED;
          end
        end
        ST_PAUSED: begin
          if (back) begin
            state_q <= ST_READY;
          end else if (pause_req) begin
            timer_run_q <= 1'b1;
            state_q     <= ST_PLAYING;
          end
        end
        ST_RESULT, ST_SOLO_OVER: begin
          if (back) begin
            game_over_q <= 1'b0;
            winner_q    <= '0;
            state_q     <= ST_READY;
          end
        end
        default: begin
          // Unused encodings fall back to a clean idle.
          timer_run_q <= 1'b0;
          game_over_q <= 1'b0;
          winner_q    <= '0;
          countdown_q <= 4'd0;
          state_q     <= ST_READY;
        end
      endcase
    end
  end

  assign state       = state_q;
  assign countdown   = countdown_q;
  assign timer_run   = timer_run_q;
  assign timer_clear = timer_clear_q;
  assign game_over   = game_over_q;
  assign winner      = winner_q;

endmodule

// File: tb/tb_match_controller.sv
module tb_match_controller;

  localparam int NP = 4;
  localparam int KW = 3;
  localparam int LW = 6;

  // Input bundle bit order: {tick, start_multi, start_solo, pause_req, back, time_up}
  localparam logic [5:0] I_NONE = 6'b000000;
  localparam logic [5:0] I_TICK = 6'b100000;
  localparam logic [5:0] I_SM   = 6'b010000;
  localparam logic [5:0] I_SS   = 6'b001000;
  localparam logic [5:0] I_PR   = 6'b000100;
  localparam logic [5:0] I_BK   = 6'b000010;
  localparam logic [5:0] I_TU   = 6'b000001;

  logic clk = 1'b0;
  logic rst;
  logic tick, start_multi, start_solo, pause_req, back, time_up;
  logic [NP*KW-1:0] ko_bus;
  logic [NP*LW-1:0] lines_bus;
  logic [2:0] state;
  logic [3:0] countdown;
  logic timer_run, timer_clear, game_over;
  logic [1:0] winner;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      tag;
    logic [2:0] st;
    logic [3:0] cd;
    logic       run;
    logic       clr;
    logic       go;
    logic [1:0] win;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  match_controller dut (
    .clk(clk), .rst(rst), .tick(tick), .start_multi(start_multi),
    .start_solo(start_solo), .pause_req(pause_req), .back(back),
    .time_up(time_up), .ko_bus(ko_bus), .lines_bus(lines_bus),
    .state(state), .countdown(countdown), .timer_run(timer_run),
    .timer_clear(timer_clear), .game_over(game_over), .winner(winner)
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_push(string tag, logic [2:0] st, logic [3:0] cd,
                             logic run, logic clr, logic gov, logic [1:0] win);
    exp_t e;
    e.tag = tag; e.st = st; e.cd = cd; e.run = run; e.clr = clr; e.go = gov; e.win = win;
    sb.push_back(e);
  endtask

  task automatic check_head();
    exp_t e;
    if (sb.size() == 0) begin
      total++; bad++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    e = sb.pop_front();
    chk({e.tag, ".state"},     32'(state),       32'(e.st));
    chk({e.tag, ".countdown"}, 32'(countdown),   32'(e.cd));
    chk({e.tag, ".timer_run"}, 32'(timer_run),   32'(e.run));
    chk({e.tag, ".timer_clr"}, 32'(timer_clear), 32'(e.clr));
    chk({e.tag, ".game_over"}, 32'(game_over),   32'(e.go));
    chk({e.tag, ".winner"},    32'(winner),      32'(e.win));
    $display("step %-14s state=%0d cd=%0d run=%0b clr=%0b go=%0b win=%0d",
             e.tag, state, countdown, timer_run, timer_clear, game_over, winner);
  endtask

  // Drive one cycle of inputs, record the expected post-edge outputs,
  // then compare just after the edge.
  task automatic go(string tag, logic [5:0] in, logic [2:0] st, logic [3:0] cd,
                    logic run, logic clr, logic gov, logic [1:0] win);
    {tick, start_multi, start_solo, pause_req, back, time_up} = in;
    expect_push(tag, st, cd, run, clr, gov, win);
    @(posedge clk); #1;
    {tick, start_multi, start_solo, pause_req, back, time_up} = I_NONE;
    check_head();
  endtask

  task automatic set_ko(int p3, int p2, int p1, int p0);
    ko_bus = {KW'(p3), KW'(p2), KW'(p1), KW'(p0)};
  endtask

  task automatic set_lines(int p3, int p2, int p1, int p0);
    lines_bus = {LW'(p3), LW'(p2), LW'(p1), LW'(p0)};
  endtask

  // Start a match and count down to PLAYING with COUNT_SECS = 3.
  task automatic to_play(string tag, logic [5:0] start);
    go({tag, "_start"}, start,  3'd1, 4'd3, 1'b0, 1'b1, 1'b0, 2'd0);
    go({tag, "_t1"},    I_TICK, 3'd1, 4'd2, 1'b0, 1'b0, 1'b0, 2'd0);
    go({tag, "_t2"},    I_TICK, 3'd1, 4'd1, 1'b0, 1'b0, 1'b0, 2'd0);
    go({tag, "_t3"},    I_TICK, 3'd2, 4'd0, 1'b1, 1'b0, 1'b0, 2'd0);
  endtask

  initial begin
    #200000;
    total++; bad++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    {tick, start_multi, start_solo, pause_req, back, time_up} = I_NONE;
    set_ko(0, 0, 0, 0);
    set_lines(0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    expect_push("reset", 3'd0, 4'd0, 1'b0, 1'b0, 1'b0, 2'd0);
    check_head();
    rst = 1'b0;
    go("idle", I_NONE, 3'd0, 4'd0, 1'b0, 1'b0, 1'b0, 2'd0);

    // Basic multiplayer countdown, then KO target ends the match
    go("cd_start", I_SM,  3'd1, 4'd3, 1'b0, 1'b1, 1'b0, 2'd0);
    go("cd_hold",  I_NONE, 3'd1, 4'd3, 1'b0, 1'b0, 1'b0, 2'd0);
    go("cd_pr_tu", I_PR | I_TU, 3'd1, 4'd3, 1'b0, 1'b0, 1'b0, 2'd0);
    go("cd_t1",    I_TICK, 3'd1, 4'd2, 1'b0, 1'b0, 1'b0, 2'd0);
    go("cd_t2",    I_TICK, 3'd1, 4'd1, 1'b0, 1'b0, 1'b0, 2'd0);
    go("cd_t3",    I_TICK, 3'd2, 4'd0, 1'b1, 1'b0, 1'b0, 2'd0);
    go("play",     I_NONE, 3'd2, 4'd0, 1'b1, 1'b0, 1'b0, 2'd0);
    set_ko(0, 2, 5, 1);
    go("ko_end",   I_NONE, 3'd4, 4'd0, 1'b0, 1'b0, 1'b1, 2'd1);
    go("res_hold", I_TU | I_PR | I_SM, 3'd4, 4'd0, 1'b0, 1'b0, 1'b1, 2'd1);
    go("res_back", I_BK,  3'd0, 4'd0, 1'b0, 1'b0, 1'b0, 2'd0);

    // KO tie resolved on lines
    set_ko(0, 0, 0, 0);
    set_lines(0, 0, 0, 0);
    to_play("tie1", I_SM);
    set_ko(1, 3, 3, 2);
    set_lines(20, 7, 4, 9);
    go("tie1_tu",  I_TU, 3'd4, 4'd0, 1'b0, 1'b0, 1'b1, 2'd2);
    go("tie1_bk",  I_BK, 3'd0, 4'd0, 1'b0, 1'b0, 1'b0, 2'd0);

    // Full tie resolved on lowest index
    set_ko(0, 0, 0, 0);
    set_lines(0, 0, 0, 0);
    to_play("tie2", I_SM);
    set_ko(1, 3, 3, 2);
    set_lines(0, 5, 5, 9);
    go("tie2_tu",  I_TU, 3'd4, 4'd0, 1'b0, 1'b0, 1'b1, 2'd1);
    go("tie2_bk",  I_BK, 3'd0, 4'd0, 1'b0, 1'b0, 1'b0, 2'd0);

    // Pause / resume / abort from pause
    set_ko(0, 0, 0, 0);
    set_lines(0, 0, 0, 0);
    to_play("pz", I_SM);
    go("pz_pause", I_PR, 3'd3, 4'd0, 1'b0, 1'b0, 1'b0, 2'd0);
    set_ko(0, 0, 0, 5);
    go("pz_ign",   I_TU, 3'd3, 4'd0, 1'b0, 1'b0, 1'b0, 2'd0);
    set_ko(0, 0, 0, 0);
    go("pz_resume", I_PR, 3'd2, 4'd0, 1'b1, 1'b0, 1'b0, 2'd0);
    go("pz_pause2", I_PR, 3'd3, 4'd0, 1'b0, 1'b0, 1'b0, 2'd0);
    go("pz_back",  I_BK | I_PR, 3'd0, 4'd0, 1'b0, 1'b0, 1'b0, 2'd0);

    // Back from PLAYING without an end condition
    to_play("pb", I_SM);
    go("pb_back",  I_BK | I_PR, 3'd0, 4'd0, 1'b0, 1'b0, 1'b0, 2'd0);

    // End condition beats back and pause in the same cycle
    to_play("sim", I_SM);
    set_lines(3, 0, 0, 0);
    go("sim_all",  I_TU | I_PR | I_BK, 3'd4, 4'd0, 1'b0, 1'b0, 1'b1, 2'd3);
    go("sim_bk",   I_BK, 3'd0, 4'd0, 1'b0, 1'b0, 1'b0, 2'd0);
    set_lines(0, 0, 0, 0);

    // Both starts together select multiplayer: KO target then ends the match
    to_play("both", I_SM | I_SS);
    set_ko(0, 0, 0, 5);
    go("both_ko",  I_NONE, 3'd4, 4'd0, 1'b0, 1'b0, 1'b1, 2'd0);
    go("both_bk",  I_BK, 3'd0, 4'd0, 1'b0, 1'b0, 1'b0, 2'd0);

    // Solo: KOs ignored, time_up ends with winner 0
    set_ko(0, 0, 0, 0);
    to_play("solo", I_SS);
    set_ko(0, 0, 5, 5);
    go("solo_ko",  I_NONE, 3'd2, 4'd0, 1'b1, 1'b0, 1'b0, 2'd0);
    go("solo_tu",  I_TU, 3'd5, 4'd0, 1'b0, 1'b0, 1'b1, 2'd0);
    go("solo_bk",  I_BK, 3'd0, 4'd0, 1'b0, 1'b0, 1'b0, 2'd0);
    set_ko(0, 0, 0, 0);

    // back beats tick in COUNTDOWN
    go("cdb_start", I_SM, 3'd1, 4'd3, 1'b0, 1'b1, 1'b0, 2'd0);
    go("cdb_back",  I_BK | I_TICK, 3'd0, 4'd0, 1'b0, 1'b0, 1'b0, 2'd0);

    // Asynchronous reset in the middle of COUNTDOWN
    go("ar_start", I_SM,  3'd1, 4'd3, 1'b0, 1'b1, 1'b0, 2'd0);
    go("ar_t1",    I_TICK, 3'd1, 4'd2, 1'b0, 1'b0, 1'b0, 2'd0);
    #2 rst = 1'b1;
    #1;
    expect_push("async_rst", 3'd0, 4'd0, 1'b0, 1'b0, 1'b0, 2'd0);
    check_head();
    @(posedge clk); #1;
    rst = 1'b0;
    go("after_rst", I_TICK, 3'd0, 4'd0, 1'b0, 1'b0, 1'b0, 2'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
